// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op codes, default
// latencies and the sequencer state encoding.
package mdu_pkg;

  localparam int unsigned MDU_OP_W = 4;

  localparam logic [MDU_OP_W-1:0] OP_NONE  = 4'd0;
  localparam logic [MDU_OP_W-1:0] OP_MULT  = 4'd1;
  localparam logic [MDU_OP_W-1:0] OP_MULTU = 4'd2;
  localparam logic [MDU_OP_W-1:0] OP_DIV   = 4'd3;
  localparam logic [MDU_OP_W-1:0] OP_DIVU  = 4'd4;
  localparam logic [MDU_OP_W-1:0] OP_MFHI  = 4'd5;
  localparam logic [MDU_OP_W-1:0] OP_MFLO  = 4'd6;
  localparam logic [MDU_OP_W-1:0] OP_MTHI  = 4'd7;
  localparam logic [MDU_OP_W-1:0] OP_MTLO  = 4'd8;

  localparam int unsigned MDU_MULT_CYCLES = 5;
  localparam int unsigned MDU_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // Ops that occupy the multi-cycle unit.
  function automatic logic is_arith(input logic [MDU_OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_mult(input logic [MDU_OP_W-1:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  // Codes above MTLO decode as NONE.
  function automatic logic is_md_op(input logic [MDU_OP_W-1:0] op);
    return (op != OP_NONE) && (op <= OP_MTLO);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing HI/LO for one MD op,
// plus a flag for a zero divisor.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [MDU_OP_W-1:0] op,
  input  logic [31:0]         a,
  input  logic [31:0]         b,
  output logic [31:0]         hi,
  output logic [31:0]         lo,
  output logic                div_zero
);

  logic               mul_signed;
  logic signed [63:0] ma;
  logic signed [63:0] mb;
  logic signed [63:0] prod;

  logic        div_signed;
  logic        neg_q;
  logic        neg_r;
  logic [31:0] ua;
  logic [31:0] ub;
  logic [31:0] uq;
  logic [31:0] ur;

  // One 64-bit multiplier serves both signednesses via the extension bit.
  assign mul_signed = (op == OP_MULT);
  assign ma   = {{32{mul_signed & a[31]}}, a};
  assign mb   = {{32{mul_signed & b[31]}}, b};
  assign prod = ma * mb;

  // Signed divide runs on magnitudes; quotient truncates toward zero and the
  // remainder takes the dividend's sign.
  assign div_signed = (op == OP_DIV);
  assign ua    = (div_signed && a[31]) ? 32'(-a) : a;
  assign ub    = (div_signed && b[31]) ? 32'(-b) : b;
  assign uq    = (ub != 32'd0) ? (ua / ub) : 32'd0;
  assign ur    = (ub != 32'd0) ? (ua % ub) : 32'd0;
  assign neg_q = div_signed & (a[31] ^ b[31]);
  assign neg_r = div_signed & a[31];

  always_comb begin
    hi       = 32'd0;
    lo       = 32'd0;
    div_zero = 1'b0;
    if (is_mult(op)) begin
      hi = prod[63:32];
      lo = prod[31:0];
    end else if ((op == OP_DIV) || (op == OP_DIVU)) begin
      div_zero = (b == 32'd0);
      lo       = neg_q ? 32'(-uq) : uq;
      hi       = neg_r ? 32'(-ur) : ur;
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// E-stage multiply/divide sequencer: owns HI/LO, launches MD ops, counts
// their latency and requests a stall for dependent MD instructions.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                E_hold,
  input  logic [MDU_OP_W-1:0] E_MDU_op,
  input  logic [31:0]         E_rs_val,
  input  logic [31:0]         E_rt_val,
  output logic                busy,
  output logic                start,
  output logic                md_stall,
  output logic [31:0]         HI,
  output logic [31:0]         LO,
  output logic [31:0]         E_MDU_out
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_skip;

  logic        fire;
  logic [31:0] arith_hi;
  logic [31:0] arith_lo;
  logic        arith_dz;

  mdu_arith u_arith (
    .op       (E_MDU_op),
    .a        (E_rs_val),
    .b        (E_rt_val),
    .hi       (arith_hi),
    .lo       (arith_lo),
    .div_zero (arith_dz)
  );

  // The E instruction takes effect at the next edge only when nothing blocks it.
  assign fire     = ~busy & ~req & ~E_hold & ~reset;
  assign start    = fire & is_arith(E_MDU_op);
  assign md_stall = busy & is_md_op(E_MDU_op);

  always_comb begin
    E_MDU_out = 32'd0;
    if (E_MDU_op == OP_MFHI) begin
      E_MDU_out = HI;
    end else if (E_MDU_op == OP_MFLO) begin
      E_MDU_out = LO;
    end
  end

  // Launched ops always run to completion; only reset discards them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      cnt       <= '0;
      HI        <= 32'd0;
      LO        <= 32'd0;
      pend_hi   <= 32'd0;
      pend_lo   <= 32'd0;
      pend_skip <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pend_hi   <= arith_hi;
            pend_lo   <= arith_lo;
            pend_skip <= arith_dz;
            cnt       <= is_mult(E_MDU_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            busy      <= 1'b1;
            state     <= ST_BUSY;
          end else if (fire && (E_MDU_op == OP_MTHI)) begin
            HI <= E_rs_val;
          end else if (fire && (E_MDU_op == OP_MTLO)) begin
            LO <= E_rs_val;
          end
        end
        ST_BUSY: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
            if (!pend_skip) begin
              HI <= pend_hi;
              LO <= pend_lo;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide sequencer for the E stage of the pipelined MIPS core. It owns the HI/LO registers and the multi-cycle latency counter, and launches mult/multu/div/divu from the E stage. It raises a stall request to the hazard control unit while an operation is in flight, serves mfhi/mflo/mthi/mtlo, and suppresses launches and HI/LO writes on an exception/interrupt flush (`req`). Its `E_MDU_out` feeds the E/M pipeline register.

## Interface
- `MULT_CYCLES`, default 5: busy cycles for mult/multu.
- `DIV_CYCLES`, default 10: busy cycles for div/divu.

- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `req` in 1: exception/interrupt flush this cycle; the E instruction is discarded.
- `E_hold` in 1: E stage held this cycle for another hazard, so the E instruction does not advance.
- `E_MDU_op` in 4: operation of the E instruction (encoding in `mdu_pkg`).
- `E_rs_val` in 32: forwarded rs operand.
- `E_rt_val` in 32: forwarded rt operand.
- `busy` out 1: operation in flight.
- `start` out 1: combinational; the E mult/div launches at the next edge.
- `md_stall` out 1: combinational; = `busy` & (`E_MDU_op` != NONE).
- `HI` out 32: architectural HI.
- `LO` out 32: architectural LO.
- `E_MDU_out` out 32: HI for MFHI, LO for MFLO, else 0 (combinational).

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8. Codes 9–15 are treated as NONE.
- `fire` = !`busy` & !`req` & !`E_hold` & !`reset`.
- `start` = `fire` & op in {MULT, MULTU, DIV, DIVU}.
- On `start`:
  - The result is computed from the current operands and latched into `pend_hi`/`pend_lo`.
  - The counter loads MULT_CYCLES or DIV_CYCLES and `busy` is set.
- Two states:
  - IDLE → BUSY on `start`.
  - BUSY: the counter decrements each cycle. On the edge where the counter goes 1→0, HI/LO ← `pend_hi`/`pend_lo` and the state returns to IDLE.
- A launched operation always completes. `req` during BUSY neither aborts it nor blocks its commit, because the instruction has already left E.
- MTHI/MTLO: HI (or LO) ← `E_rs_val` at the edge when `fire`.
- Arithmetic:
  - mult is a signed 32×32→64 multiply; multu is unsigned. HI = product[63:32], LO = product[31:0].
  - div is signed, with LO = quotient truncated toward zero and HI = remainder carrying the dividend's sign. divu is unsigned.
  - 0x80000000 div 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
  - A divisor of 0 launches and stalls normally, but HI/LO are left unchanged at commit.
- Reset values: `busy`=0, counter=0, state IDLE, HI=0, LO=0, pending registers=0. `start`, `md_stall` and `E_MDU_out` follow from these.

## Timing
- If `start` is high in cycle t:
  - `busy` is 1 in cycles t+1 … t+N.
  - New HI/LO are visible from cycle t+N+1, the same cycle `busy` falls.
- The launching instruction advances in cycle t (no self-stall). The next MD-type instruction stalls until `busy`=0, so back-to-back mult→mflo reads the result exactly in cycle t+N+1.
- `req` and `start` conditions in the same cycle: no launch, no HI/LO change.
- MTHI/MTLO in the same cycle as `req`: no write.
- `reset` mid-operation: the pending result is discarded; all state returns to reset values at that edge.
- Commit and a new launch cannot coincide, because a launch requires `busy`=0.

## Structure
- `mdu_pkg`: op-code constants, the default latencies, and the state encoding.
- `mdu_arith`: combinational sub-module taking op, a, b and producing hi, lo and a `div_zero` flag.
- `mdu_ctrl`: the FSM, the counter, HI/LO and pending registers, and the output muxing.

## Test plan
- Reset, then MULT with rs=0xFFFFFFFE (−2), rt=3 → `busy` for 5 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU on the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV with rs=−7, rt=2 → `busy` for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. An MFLO held in E during that time sees `md_stall`=1 in each busy cycle, then `E_MDU_out`=0xFFFFFFFD in cycle t+11.
- DIVU with rt=0, HI=0x11, LO=0x22 beforehand → `busy` for 10 cycles, then HI/LO remain 0x11/0x22.
- `req`=1 with MULT in E → `start`=0, `busy` stays 0, HI/LO unchanged. MTHI 0x5 with `req`=1 → HI unchanged.
- `req` pulse in cycle t+2 of a MULT → completes normally with the committed result. `reset` in cycle t+3 of a DIV → `busy`=0 and HI=LO=0 next cycle, with no later commit.
- `E_hold`=1 with MULT in E for 2 cycles → no launch. Releasing `E_hold` → exactly one launch and exactly 5 busy cycles.
